// File: rtl/axil_pkg.sv
`default_nettype none
// ============================================================================
// Module : axil_pkg
// Brief  : Shared FSM state encoding, AXI response codes and default widths.
// Rev    : 1.0 - initial release
// ============================================================================
package axil_pkg;

  localparam int c_addr_w_def = 32;
  localparam int c_cnt_w_def  = 16;
  localparam int c_data_w     = 32;
  localparam int c_strb_w     = 4;

  localparam logic [1:0] c_resp_okay   = 2'b00;
  localparam logic [1:0] c_resp_slverr = 2'b10;
  localparam logic [1:0] c_resp_decerr = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_WR_B = 3'd2,
    ST_RD_A = 3'd3,
    ST_RD_R = 3'd4,
    ST_RSP  = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/axil_cmd_master.sv
`default_nettype none
// ============================================================================
// Module : axil_cmd_master
// Brief  : Single-outstanding command-to-AXI4-Lite master with statistics.
// Rev    : 1.0 - initial release
// ============================================================================
module axil_cmd_master
  import axil_pkg::*;
#(
  parameter int ADDR_W = c_addr_w_def,
  parameter int CNT_W  = c_cnt_w_def
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [c_data_w-1:0] cmd_wdata,
  input  logic [c_strb_w-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_write,
  output logic [c_data_w-1:0] rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic [ADDR_W-1:0]   M_AXIL_AWADDR,
  output logic [2:0]          M_AXIL_AWPROT,
  output logic                M_AXIL_AWVALID,
  input  logic                M_AXIL_AWREADY,
  output logic [c_data_w-1:0] M_AXIL_WDATA,
  output logic [c_strb_w-1:0] M_AXIL_WSTRB,
  output logic                M_AXIL_WVALID,
  input  logic                M_AXIL_WREADY,
  input  logic [1:0]          M_AXIL_BRESP,
  input  logic                M_AXIL_BVALID,
  output logic                M_AXIL_BREADY,
  output logic [ADDR_W-1:0]   M_AXIL_ARADDR,
  output logic [2:0]          M_AXIL_ARPROT,
  output logic                M_AXIL_ARVALID,
  input  logic                M_AXIL_ARREADY,
  input  logic [c_data_w-1:0] M_AXIL_RDATA,
  input  logic [1:0]          M_AXIL_RRESP,
  input  logic                M_AXIL_RVALID,
  output logic                M_AXIL_RREADY,
  output logic [CNT_W-1:0]    wr_count,
  output logic [CNT_W-1:0]    rd_count,
  output logic [CNT_W-1:0]    err_count
);

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_aw_done;
  logic                  r_w_done;
  logic [ADDR_W-1:0]     r_addr;
  logic [c_data_w-1:0]   r_wdata;
  logic [c_strb_w-1:0]   r_wstrb;
  logic                  r_write;
  logic [c_data_w-1:0]   r_rdata;
  logic [1:0]            r_resp;
  logic [CNT_W-1:0]      r_wr_cnt;
  logic [CNT_W-1:0]      r_rd_cnt;
  logic [CNT_W-1:0]      r_err_cnt;

  logic w_cmd_fire;
  logic w_aw_fire;
  logic w_w_fire;
  logic w_b_fire;
  logic w_r_fire;
  logic w_rsp_fire;

  always_ff @(posedge ACLK) begin
    if (ARESET) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // All handshake outputs decode from registered state only, so nothing
  // combinationally loops back to the slave's READY/VALID inputs.
  always_comb begin
    w_state_nxt    = r_state;
    cmd_ready      = 1'b0;
    rsp_valid      = 1'b0;
    M_AXIL_AWVALID = 1'b0;
    M_AXIL_WVALID  = 1'b0;
    M_AXIL_BREADY  = 1'b0;
    M_AXIL_ARVALID = 1'b0;
    M_AXIL_RREADY  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cmd_ready = !ARESET;
        if (cmd_valid) w_state_nxt = cmd_write ? ST_WR : ST_RD_A;
      end
      ST_WR: begin
        M_AXIL_AWVALID = !r_aw_done;
        M_AXIL_WVALID  = !r_w_done;
        if ((r_aw_done || M_AXIL_AWREADY) && (r_w_done || M_AXIL_WREADY))
          w_state_nxt = ST_WR_B;
      end
      ST_WR_B: begin
        M_AXIL_BREADY = 1'b1;
        if (M_AXIL_BVALID) w_state_nxt = ST_RSP;
      end
      ST_RD_A: begin
        M_AXIL_ARVALID = 1'b1;
        if (M_AXIL_ARREADY) w_state_nxt = ST_RD_R;
      end
      ST_RD_R: begin
        M_AXIL_RREADY = 1'b1;
        if (M_AXIL_RVALID) w_state_nxt = ST_RSP;
      end
      ST_RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_cmd_fire = cmd_valid && cmd_ready;
  assign w_aw_fire  = M_AXIL_AWVALID && M_AXIL_AWREADY;
  assign w_w_fire   = M_AXIL_WVALID && M_AXIL_WREADY;
  assign w_b_fire   = M_AXIL_BVALID && M_AXIL_BREADY;
  assign w_r_fire   = M_AXIL_RVALID && M_AXIL_RREADY;
  assign w_rsp_fire = rsp_valid && rsp_ready;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_write   <= 1'b0;
      r_rdata   <= '0;
      r_resp    <= c_resp_okay;
      r_wr_cnt  <= '0;
      r_rd_cnt  <= '0;
      r_err_cnt <= '0;
    end else begin
      if (w_cmd_fire) begin
        r_addr  <= cmd_addr;
        r_wdata <= cmd_wdata;
        r_wstrb <= cmd_wstrb;
        r_write <= cmd_write;
      end
      // AW and W complete independently; each flag retires its own VALID.
      if (r_state != ST_WR) begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end else begin
        if (w_aw_fire) r_aw_done <= 1'b1;
        if (w_w_fire)  r_w_done  <= 1'b1;
      end
      if (w_b_fire) begin
        r_rdata <= '0;
        r_resp  <= M_AXIL_BRESP;
      end
      if (w_r_fire) begin
        r_rdata <= M_AXIL_RDATA;
        r_resp  <= M_AXIL_RRESP;
      end
      if (w_rsp_fire) begin
        if (r_write) begin
          if (r_wr_cnt != c_cnt_max) r_wr_cnt <= r_wr_cnt + c_cnt_one;
        end else begin
          if (r_rd_cnt != c_cnt_max) r_rd_cnt <= r_rd_cnt + c_cnt_one;
        end
        if ((r_resp != c_resp_okay) && (r_err_cnt != c_cnt_max))
          r_err_cnt <= r_err_cnt + c_cnt_one;
      end
    end
  end

  assign M_AXIL_AWADDR = r_addr;
  assign M_AXIL_AWPROT = 3'b000;
  assign M_AXIL_WDATA  = r_wdata;
  assign M_AXIL_WSTRB  = r_wstrb;
  assign M_AXIL_ARADDR = r_addr;
  assign M_AXIL_ARPROT = 3'b000;

  assign rsp_write = r_write;
  assign rsp_rdata = r_rdata;
  assign rsp_resp  = r_resp;
  assign wr_count  = r_wr_cnt;
  assign rd_count  = r_rd_cnt;
  assign err_count = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_axil_cmd_master.sv
`default_nettype none
// ============================================================================
// Module : tb_axil_cmd_master
// Brief  : Self-checking bench: master plus stall-injecting AXI-Lite memory.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_axil_cmd_master;

  localparam int c_cnt_w = 4;
  localparam int c_cmax  = (1 << c_cnt_w) - 1;
  localparam int c_nvec  = 11;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] M_AXIL_AWADDR, M_AXIL_WDATA, M_AXIL_ARADDR, M_AXIL_RDATA;
  logic [2:0]  M_AXIL_AWPROT, M_AXIL_ARPROT;
  logic        M_AXIL_AWVALID, M_AXIL_AWREADY, M_AXIL_WVALID, M_AXIL_WREADY;
  logic [3:0]  M_AXIL_WSTRB;
  logic [1:0]  M_AXIL_BRESP, M_AXIL_RRESP;
  logic        M_AXIL_BVALID, M_AXIL_BREADY, M_AXIL_ARVALID, M_AXIL_ARREADY;
  logic        M_AXIL_RVALID, M_AXIL_RREADY;
  logic [c_cnt_w-1:0] wr_count, rd_count, err_count;

  always #5 ACLK = ~ACLK;

  axil_cmd_master #(.ADDR_W(32), .CNT_W(c_cnt_w)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .M_AXIL_AWADDR(M_AXIL_AWADDR), .M_AXIL_AWPROT(M_AXIL_AWPROT),
    .M_AXIL_AWVALID(M_AXIL_AWVALID), .M_AXIL_AWREADY(M_AXIL_AWREADY),
    .M_AXIL_WDATA(M_AXIL_WDATA), .M_AXIL_WSTRB(M_AXIL_WSTRB),
    .M_AXIL_WVALID(M_AXIL_WVALID), .M_AXIL_WREADY(M_AXIL_WREADY),
    .M_AXIL_BRESP(M_AXIL_BRESP), .M_AXIL_BVALID(M_AXIL_BVALID),
    .M_AXIL_BREADY(M_AXIL_BREADY),
    .M_AXIL_ARADDR(M_AXIL_ARADDR), .M_AXIL_ARPROT(M_AXIL_ARPROT),
    .M_AXIL_ARVALID(M_AXIL_ARVALID), .M_AXIL_ARREADY(M_AXIL_ARREADY),
    .M_AXIL_RDATA(M_AXIL_RDATA), .M_AXIL_RRESP(M_AXIL_RRESP),
    .M_AXIL_RVALID(M_AXIL_RVALID), .M_AXIL_RREADY(M_AXIL_RREADY),
    .wr_count(wr_count), .rd_count(rd_count), .err_count(err_count)
  );

  // ---------------- stall-injecting AXI-Lite memory slave ----------------
  int         cfg_aw_stall = 0, cfg_w_stall = 0, cfg_ar_stall = 0, cfg_b_stall = 0;
  logic [1:0] cfg_bresp = 2'b00, cfg_rresp = 2'b00;

  logic [31:0] mem [0:63] = '{default: 32'h0};
  logic        s_aw_got, s_w_got, s_bvalid, s_rvalid;
  logic [31:0] s_awaddr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_bresp, s_rresp;
  int          s_aw_cnt, s_w_cnt, s_ar_cnt, s_b_cnt;
  logic        sl_aw_fire, sl_w_fire, sl_ar_fire, sl_have_aw, sl_have_w;
  logic [31:0] sl_addr, sl_wd;
  logic [3:0]  sl_ws;

  assign M_AXIL_AWREADY = M_AXIL_AWVALID && !s_aw_got && !s_bvalid && (s_aw_cnt >= cfg_aw_stall);
  assign M_AXIL_WREADY  = M_AXIL_WVALID && !s_w_got && !s_bvalid && (s_w_cnt >= cfg_w_stall);
  assign M_AXIL_ARREADY = M_AXIL_ARVALID && !s_rvalid && (s_ar_cnt >= cfg_ar_stall);
  assign M_AXIL_BVALID  = s_bvalid && (s_b_cnt >= cfg_b_stall);
  assign M_AXIL_BRESP   = s_bresp;
  assign M_AXIL_RVALID  = s_rvalid;
  assign M_AXIL_RDATA   = s_rdata;
  assign M_AXIL_RRESP   = s_rresp;
  assign sl_aw_fire = M_AXIL_AWVALID && M_AXIL_AWREADY;
  assign sl_w_fire  = M_AXIL_WVALID && M_AXIL_WREADY;
  assign sl_ar_fire = M_AXIL_ARVALID && M_AXIL_ARREADY;
  assign sl_have_aw = s_aw_got || sl_aw_fire;
  assign sl_have_w  = s_w_got || sl_w_fire;
  assign sl_addr = s_aw_got ? s_awaddr : M_AXIL_AWADDR;
  assign sl_wd   = s_w_got ? s_wdata : M_AXIL_WDATA;
  assign sl_ws   = s_w_got ? s_wstrb : M_AXIL_WSTRB;

  always @(posedge ACLK) begin
    if (ARESET) begin
      s_aw_got <= 1'b0; s_w_got <= 1'b0; s_bvalid <= 1'b0; s_rvalid <= 1'b0;
      s_awaddr <= '0; s_wdata <= '0; s_wstrb <= '0; s_rdata <= '0;
      s_bresp <= '0; s_rresp <= '0;
      s_aw_cnt <= 0; s_w_cnt <= 0; s_ar_cnt <= 0; s_b_cnt <= 0;
    end else begin
      if (sl_aw_fire) begin s_aw_cnt <= 0; s_awaddr <= M_AXIL_AWADDR; end
      else if (M_AXIL_AWVALID) s_aw_cnt <= s_aw_cnt + 1;
      if (sl_w_fire) begin s_w_cnt <= 0; s_wdata <= M_AXIL_WDATA; s_wstrb <= M_AXIL_WSTRB; end
      else if (M_AXIL_WVALID) s_w_cnt <= s_w_cnt + 1;
      if (sl_have_aw && sl_have_w && !s_bvalid) begin
        for (int b = 0; b < 4; b++)
          if (sl_ws[b]) mem[sl_addr[7:2]][8*b +: 8] <= sl_wd[8*b +: 8];
        s_aw_got <= 1'b0; s_w_got <= 1'b0;
        s_bvalid <= 1'b1; s_bresp <= cfg_bresp; s_b_cnt <= 0;
      end else begin
        if (sl_aw_fire) s_aw_got <= 1'b1;
        if (sl_w_fire)  s_w_got  <= 1'b1;
      end
      if (s_bvalid) begin
        if (M_AXIL_BVALID && M_AXIL_BREADY) s_bvalid <= 1'b0;
        else s_b_cnt <= s_b_cnt + 1;
      end
      if (sl_ar_fire) begin
        s_ar_cnt <= 0; s_rvalid <= 1'b1;
        s_rdata <= mem[M_AXIL_ARADDR[7:2]]; s_rresp <= cfg_rresp;
      end else if (M_AXIL_ARVALID) s_ar_cnt <= s_ar_cnt + 1;
      if (s_rvalid && M_AXIL_RREADY) s_rvalid <= 1'b0;
    end
  end

  // ---------------- monitor: records handshakes at the falling edge ----------------
  int          cyc = 0, acc_cyc = 0, acc_cnt = 0, obs_cnt = 0;
  int          aw_hi = 0, w_hi = 0, aw_hs = 0, rspv_hi = 0;
  logic        obs_write [0:255];
  logic [31:0] obs_rdata [0:255];
  logic [1:0]  obs_resp  [0:255];
  int          obs_lat   [0:255];

  always @(posedge ACLK) cyc <= cyc + 1;

  always @(negedge ACLK) begin
    if (!ARESET) begin
      if (cmd_valid && cmd_ready) begin acc_cyc <= cyc; acc_cnt <= acc_cnt + 1; end
      if (rsp_valid && rsp_ready && obs_cnt < 256) begin
        obs_write[obs_cnt] <= rsp_write;
        obs_rdata[obs_cnt] <= rsp_rdata;
        obs_resp[obs_cnt]  <= rsp_resp;
        obs_lat[obs_cnt]   <= cyc - acc_cyc;
        obs_cnt <= obs_cnt + 1;
      end
      if (M_AXIL_AWVALID) aw_hi <= aw_hi + 1;
      if (M_AXIL_WVALID)  w_hi  <= w_hi + 1;
      if (M_AXIL_AWVALID && M_AXIL_AWREADY) aw_hs <= aw_hs + 1;
      if (rsp_valid) rspv_hi <= rspv_hi + 1;
    end
  end

  // ---------------- scoreboard, vectors and driver ----------------
  typedef struct {
    logic        write;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          lat;
  } exp_t;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          aw_stall, w_stall, ar_stall, b_stall;
    logic [1:0]  inj_resp;
    int          rsp_hold;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    int          exp_lat;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[c_nvec];
  int   checks = 0, failures = 0, rd_idx = 0;
  int   m_wr = 0, m_rd = 0, m_err = 0;

  function automatic vec_t mk(logic w, logic [31:0] a, logic [31:0] d, logic [3:0] s,
                              int aws, int ws, int ars, logic [1:0] inj, int hold,
                              logic [31:0] er, logic [1:0] es, int el);
    vec_t v;
    v.write = w; v.addr = a; v.wdata = d; v.wstrb = s;
    v.aw_stall = aws; v.w_stall = ws; v.ar_stall = ars; v.b_stall = 0;
    v.inj_resp = inj; v.rsp_hold = hold;
    v.exp_rdata = er; v.exp_resp = es; v.exp_lat = el;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check_counters(input string tag);
    chk({tag, ".wr_count"}, 32'(wr_count), m_wr);
    chk({tag, ".rd_count"}, 32'(rd_count), m_rd);
    chk({tag, ".err_count"}, 32'(err_count), m_err);
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int   acc0;
    bit   ok;
    exp_t e;
    cfg_aw_stall = v.aw_stall; cfg_w_stall = v.w_stall;
    cfg_ar_stall = v.ar_stall; cfg_b_stall = v.b_stall;
    cfg_bresp = v.inj_resp; cfg_rresp = v.inj_resp;
    @(posedge ACLK); #1;
    acc0 = acc_cnt;
    cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr;
    cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
    rsp_ready = (v.rsp_hold == 0);
    exp_q.push_back('{v.write, v.exp_rdata, v.exp_resp, v.exp_lat});
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(posedge ACLK); #1;
      if (acc_cnt != acc0) begin ok = 1'b1; break; end
    end
    cmd_valid = 1'b0;
    if (!ok) begin
      chk({tag, ".accept_timeout"}, 32'(ok), 32'd1);
      exp_q.delete();
      rsp_ready = 1'b1;
      return;
    end
    if (v.rsp_hold > 0) begin
      ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
        if (rsp_valid) begin ok = 1'b1; break; end
        @(posedge ACLK); #1;
      end
      chk({tag, ".hold_wait"}, 32'(ok), 32'd1);
      for (int h = 0; h < v.rsp_hold; h++) begin
        chk({tag, ".hold_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, ".hold_rdata"}, rsp_rdata, v.exp_rdata);
        chk({tag, ".hold_cmd_ready"}, 32'(cmd_ready), 32'd0);
        @(posedge ACLK); #1;
      end
      rsp_ready = 1'b1;
    end
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (obs_cnt > rd_idx) begin ok = 1'b1; break; end
      @(posedge ACLK); #1;
    end
    if (!ok) begin
      chk({tag, ".rsp_timeout"}, 32'(ok), 32'd1);
      exp_q.delete();
      return;
    end
    e = exp_q.pop_front();
    chk({tag, ".rsp_write"}, 32'(obs_write[rd_idx]), 32'(e.write));
    chk({tag, ".rsp_rdata"}, obs_rdata[rd_idx], e.rdata);
    chk({tag, ".rsp_resp"}, 32'(obs_resp[rd_idx]), 32'(e.resp));
    if (e.lat != 0) chk({tag, ".latency"}, obs_lat[rd_idx], e.lat);
    rd_idx++;
    if (e.write) begin if (m_wr < c_cmax) m_wr++; end
    else begin if (m_rd < c_cmax) m_rd++; end
    if (e.resp != 2'b00 && m_err < c_cmax) m_err++;
    check_counters(tag);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int   aw0, w0, hs0, obs0, rv0;
    bit   ok;
    vec_t v;
    ARESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b1;

    vecs[0]  = mk(1, 32'h40, 32'hA5A5_1234, 4'hF, 0, 0, 0, 2'b00, 0, 32'h0,         2'b00, 3);
    vecs[1]  = mk(0, 32'h40, 32'h0,         4'h0, 0, 0, 0, 2'b00, 0, 32'hA5A5_1234, 2'b00, 3);
    vecs[2]  = mk(1, 32'h80, 32'h1122_3344, 4'hF, 0, 0, 0, 2'b00, 0, 32'h0,         2'b00, 0);
    vecs[3]  = mk(1, 32'h80, 32'hFFFF_BEEF, 4'h3, 0, 0, 0, 2'b00, 0, 32'h0,         2'b00, 0);
    vecs[4]  = mk(0, 32'h80, 32'h0,         4'h0, 0, 0, 0, 2'b00, 0, 32'h1122_BEEF, 2'b00, 0);
    vecs[5]  = mk(0, 32'h40, 32'h0,         4'h0, 0, 0, 0, 2'b10, 0, 32'hA5A5_1234, 2'b10, 0);
    vecs[6]  = mk(1, 32'h44, 32'h0BAD_F00D, 4'hC, 3, 0, 0, 2'b00, 0, 32'h0,         2'b00, 0);
    vecs[7]  = mk(0, 32'h44, 32'h0,         4'h0, 0, 0, 2, 2'b00, 0, 32'h0BAD_0000, 2'b00, 0);
    vecs[8]  = mk(1, 32'h48, 32'h1234_5678, 4'hF, 0, 0, 0, 2'b11, 0, 32'h0,         2'b11, 0);
    vecs[9]  = mk(0, 32'hC0, 32'h0,         4'h0, 0, 0, 0, 2'b00, 0, 32'h0,         2'b00, 3);
    vecs[10] = mk(0, 32'h48, 32'h0,         4'h0, 0, 0, 0, 2'b00, 0, 32'h1234_5678, 2'b00, 0);

    repeat (3) @(posedge ACLK);
    #1;
    chk("reset.cmd_ready", 32'(cmd_ready), 32'd0);
    chk("reset.valids", 32'({rsp_valid, M_AXIL_AWVALID, M_AXIL_WVALID, M_AXIL_BREADY,
                             M_AXIL_ARVALID, M_AXIL_RREADY}), 32'd0);
    check_counters("reset");
    ARESET = 1'b0;
    #1;
    chk("release.cmd_ready", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < c_nvec; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // W stalled five cycles, AW ready at once
    aw0 = aw_hi; w0 = w_hi; hs0 = aw_hs;
    run_txn(mk(1, 32'h50, 32'hCAFE_BABE, 4'hF, 0, 5, 0, 2'b00, 0, 32'h0, 2'b00, 0), "wstall");
    chk("wstall.awvalid_cycles", aw_hi - aw0, 1);
    chk("wstall.wvalid_cycles", w_hi - w0, 6);
    chk("wstall.aw_handshakes", aw_hs - hs0, 1);

    // response held off for four cycles
    run_txn(mk(0, 32'h50, 32'h0, 4'h0, 0, 0, 0, 2'b00, 4, 32'hCAFE_BABE, 2'b00, 0), "rsphold");

    // reset pulse while waiting for B
    v = mk(1, 32'h54, 32'h5555_AAAA, 4'hF, 0, 0, 0, 2'b00, 0, 32'h0, 2'b00, 0);
    cfg_b_stall = 10;
    @(posedge ACLK); #1;
    cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr;
    cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge ACLK); #1;
      cmd_valid = 1'b0;
      if (M_AXIL_BREADY) begin ok = 1'b1; break; end
    end
    chk("rstmid.reach_wr_b", 32'(ok), 32'd1);
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    chk("rstmid.valids", 32'({cmd_ready, rsp_valid, M_AXIL_AWVALID, M_AXIL_WVALID,
                              M_AXIL_BREADY, M_AXIL_ARVALID, M_AXIL_RREADY}), 32'd0);
    chk("rstmid.rsp_data", rsp_rdata | 32'({rsp_resp, rsp_write}), 32'd0);
    m_wr = 0; m_rd = 0; m_err = 0;
    exp_q.delete();
    check_counters("rstmid");
    ARESET = 1'b0;
    cfg_b_stall = 0;
    #1;
    chk("rstmid.cmd_ready_after", 32'(cmd_ready), 32'd1);
    obs0 = obs_cnt; rv0 = rspv_hi;
    repeat (20) @(posedge ACLK);
    #1;
    chk("rstmid.no_response", obs_cnt - obs0, 0);
    chk("rstmid.no_rsp_valid", rspv_hi - rv0, 0);
    rd_idx = obs_cnt;

    // counters saturate at all-ones
    for (int i = 0; i < c_cmax + 2; i++)
      run_txn(mk(1, 32'h60, 32'(i), 4'hF, 0, 0, 0, 2'b00, 0, 32'h0, 2'b00, 0),
              $sformatf("sat%0d", i));
    chk("sat.wr_count_max", 32'(wr_count), c_cmax);
    run_txn(mk(0, 32'h60, 32'h0, 4'h0, 0, 0, 0, 2'b00, 0, 32'(c_cmax + 1), 2'b00, 3), "satrd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
